// File: rtl/morse_pkg.sv
// Morse keyer shared types: FSM states, ROM code word, constants.
// Imported by the interface, ROM and keyer top.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ESPACE,
    CGAP,
    WGAP
  } state_t;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_if.sv
// Character handshake into the keyer.
// master: source drives in_valid/in_char; slave: keyer drives in_ready.
interface morse_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;

  modport master (
    output in_valid,
    output in_char,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_char,
    output in_ready
  );

endinterface

// File: rtl/morse_rom.sv
// ASCII to Morse code lookup; folds A-Z onto a-z.
// ch in; valid (supported letter/digit), code {len, pat} out; pat[len-1] first, 1=dash.
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid,
  output code_t      code
);

  logic [7:0] lc;

  always_comb begin
    lc = ch;
    if (ch >= 8'h41 && ch <= 8'h5a)
      lc = ch + 8'h20;
  end

  always_comb begin
    valid = 1'b1;
    code  = '0;
    case (lc)
      8'h61: code = {3'd2, 5'b00001};
      8'h62: code = {3'd4, 5'b01000};
      8'h63: code = {3'd4, 5'b01010};
      8'h64: code = {3'd3, 5'b00100};
      8'h65: code = {3'd1, 5'b00000};
      8'h66: code = {3'd4, 5'b00010};
      8'h67: code = {3'd3, 5'b00110};
      8'h68: code = {3'd4, 5'b00000};
      8'h69: code = {3'd2, 5'b00000};
      8'h6a: code = {3'd4, 5'b00111};
      8'h6b: code = {3'd3, 5'b00101};
      8'h6c: code = {3'd4, 5'b00100};
      8'h6d: code = {3'd2, 5'b00011};
      8'h6e: code = {3'd2, 5'b00010};
      8'h6f: code = {3'd3, 5'b00111};
      8'h70: code = {3'd4, 5'b00110};
      8'h71: code = {3'd4, 5'b01101};
      8'h72: code = {3'd3, 5'b00010};
      8'h73: code = {3'd3, 5'b00000};
      8'h74: code = {3'd1, 5'b00001};
      8'h75: code = {3'd3, 5'b00001};
      8'h76: code = {3'd4, 5'b00001};
      8'h77: code = {3'd3, 5'b00011};
      8'h78: code = {3'd4, 5'b01001};
      8'h79: code = {3'd4, 5'b01011};
      8'h7a: code = {3'd4, 5'b01100};
      8'h30: code = {3'd5, 5'b11111};
      8'h31: code = {3'd5, 5'b01111};
      8'h32: code = {3'd5, 5'b00111};
      8'h33: code = {3'd5, 5'b00011};
      8'h34: code = {3'd5, 5'b00001};
      8'h35: code = {3'd5, 5'b00000};
      8'h36: code = {3'd5, 5'b10000};
      8'h37: code = {3'd5, 5'b11000};
      8'h38: code = {3'd5, 5'b11100};
      8'h39: code = {3'd5, 5'b11110};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Variable-length Morse keyer: ASCII in over src handshake, keyed tone on dout.
// Ports: clk, rst (async high), src (slave), abort, dout, busy, char_done, bad_char.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int DOT_CYCLES = 5000000,
  parameter int DASH_UNITS = 3,
  parameter int CHAR_GAP   = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic   clk,
  input  logic   rst,
  morse_if.slave src,
  input  logic   abort,
  output logic   dout,
  output logic   busy,
  output logic   char_done,
  output logic   bad_char
);

  if (DOT_CYCLES < 1 || DASH_UNITS < 1 || DASH_UNITS > 7 ||
      CHAR_GAP < 1 || CHAR_GAP > 7 ||
      WORD_GAP - CHAR_GAP < 1 || WORD_GAP - CHAR_GAP > 7) begin : g_bad
    $error("morse_keyer: illegal unit parameters");
  end

  localparam int CW = $clog2(DOT_CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(DOT_CYCLES - 1);
  localparam logic [2:0] DASH_N = 3'(DASH_UNITS);
  localparam logic [2:0] CGAP_N = 3'(CHAR_GAP);
  localparam logic [2:0] WGAP_N = 3'(WORD_GAP - CHAR_GAP);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    unit_q, unit_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    pat_q, pat_d;
  logic          rdy_q;
  logic          rom_valid;
  code_t         rom_code;
  logic          xfer, is_space;
  logic          tick, seg_end, dash, last_d;

  morse_rom u_rom (
    .ch   (src.in_char),
    .valid(rom_valid),
    .code (rom_code)
  );

  function automatic logic [2:0] seg_units(state_t s, logic d);
    case (s)
      MARK:    seg_units = d ? DASH_N : 3'd1;
      CGAP:    seg_units = CGAP_N;
      WGAP:    seg_units = WGAP_N;
      default: seg_units = 3'd1;
    endcase
  endfunction

  assign src.in_ready = rdy_q;
  assign xfer     = src.in_valid && (state_q == IDLE);
  assign is_space = src.in_char == ASCII_SPACE;
  assign dash     = pat_q[idx_q];
  assign tick     = cyc_q == CYC_LAST;
  assign seg_end  = tick &&
    (unit_q == seg_units(state_q, dash) - 3'd1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (xfer && is_space) begin
          state_d = WGAP;
        end else if (xfer && rom_valid) begin
          state_d = MARK;
          pat_d   = rom_code.pat;
          idx_d   = rom_code.len - 3'd1;
        end
      end
      MARK:
        if (seg_end)
          state_d = (idx_q == 3'd0) ? CGAP : ESPACE;
      ESPACE:
        if (seg_end) begin
          state_d = MARK;
          idx_d   = idx_q - 3'd1;
        end
      CGAP, WGAP:
        if (seg_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE)
      state_d = IDLE;
  end

  // Timers restart on every state entry, so each segment starts at zero.
  always_comb begin
    cyc_d  = cyc_q + CW'(1);
    unit_d = unit_q;
    if (state_d != state_q || state_q == IDLE) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (tick) begin
      cyc_d  = '0;
      unit_d = unit_q + 3'd1;
    end
  end

  // char_done is registered, so detect the final gap cycle one cycle early.
  assign last_d = (state_d == CGAP || state_d == WGAP) &&
    cyc_d == CYC_LAST &&
    unit_d == seg_units(state_d, 1'b0) - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      unit_q    <= '0;
      idx_q     <= '0;
      pat_q     <= '0;
      rdy_q     <= 1'b1;
      dout      <= 1'b0;
      busy      <= 1'b0;
      char_done <= 1'b0;
      bad_char  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      rdy_q     <= state_d == IDLE;
      dout      <= state_d == MARK;
      busy      <= state_d != IDLE;
      char_done <= last_d;
      bad_char  <= xfer && !is_space && !rom_valid;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: Morse timing model plus directed characters.
// Two keyers: DOT_CYCLES=4 (index 0) and DOT_CYCLES=1 (index 1).
module tb_morse_keyer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort4 = 1'b0, abort1 = 1'b0;
  logic dout4, busy4, cd4, bad4;
  logic dout1, busy1, cd1, bad1;
  int   vecs = 0;
  int   errs = 0;

  morse_if bus4 ();
  morse_if bus1 ();

  always #5 clk = ~clk;

  morse_keyer #(.DOT_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .src(bus4), .abort(abort4),
    .dout(dout4), .busy(busy4),
    .char_done(cd4), .bad_char(bad4)
  );

  morse_keyer #(.DOT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .src(bus1), .abort(abort1),
    .dout(dout1), .busy(busy1),
    .char_done(cd1), .bad_char(bad1)
  );

  string lt [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.",
    "--.", "....", "..", ".---", "-.-", ".-..", "--", "-.",
    "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-",
    ".--", "-..-", "-.--", "--.."};
  string dg [10] = '{"-----", ".----", "..---", "...--",
    "....-", ".....", "-....", "--...", "---..", "----."};

  function automatic string pat_of(logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= 8'h41 && u <= 8'h5a) u = u + 8'd32;
    if (u >= 8'h61 && u <= 8'h7a) return lt[int'(u) - 97];
    if (u >= 8'h30 && u <= 8'h39) return dg[int'(u) - 48];
    return "";
  endfunction

  // Total cycles a character occupies, gap included.
  function automatic int len_of(logic [7:0] c, int d);
    string m;
    int n;
    if (c == 8'h20) return 4 * d;
    m = pat_of(c);
    n = 0;
    for (int i = 0; i < m.len(); i++)
      n += (m[i] == 8'h2d ? 3 : 1) + (i < m.len() - 1 ? 1 : 0);
    return (n + 3) * d;
  endfunction

  // {dout, char_done} at offset t after the transfer.
  function automatic logic [1:0] exp_at(logic [7:0] c, int d, int t);
    string m;
    int pos, w;
    if (c == 8'h20) return {1'b0, t == 4 * d - 1};
    m = pat_of(c);
    pos = 0;
    for (int i = 0; i < m.len(); i++) begin
      w = (m[i] == 8'h2d ? 3 : 1) * d;
      if (t < pos + w) return 2'b10;
      pos += w;
      if (i < m.len() - 1) begin
        if (t < pos + d) return 2'b00;
        pos += d;
      end
    end
    return {1'b0, t == pos + 3 * d - 1};
  endfunction

  function automatic int dcyc(int k);
    return k == 0 ? 4 : 1;
  endfunction

  int         act [2] = '{0, 0};
  int         tt  [2] = '{0, 0};
  int         nx  [2] = '{0, 0};
  bit         xbad[2] = '{0, 0};
  logic [7:0] cc  [2] = '{8'h0, 8'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        act[k]  = 0;
        tt[k]   = 0;
        xbad[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic       v, ab;
        logic [7:0] ch;
        v  = k == 0 ? bus4.in_valid : bus1.in_valid;
        ch = k == 0 ? bus4.in_char : bus1.in_char;
        ab = k == 0 ? abort4 : abort1;
        xbad[k] = 1'b0;
        if (act[k] != 0) begin
          if (ab) act[k] = 0;
          else begin
            tt[k]++;
            if (tt[k] >= len_of(cc[k], dcyc(k))) act[k] = 0;
          end
        end else if (v) begin
          nx[k]++;
          if (ch == 8'h20 || pat_of(ch) != "") begin
            act[k] = 1;
            tt[k]  = 0;
            cc[k]  = ch;
          end else xbad[k] = 1'b1;
        end
      end
    end
  end

  int hi[2] = '{0, 0}, bz[2] = '{0, 0}, nd[2] = '{0, 0};
  int nb[2] = '{0, 0}, nr[2] = '{0, 0};

  task automatic chk(input string nm, input longint a,
                     input longint e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, e);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [1:0] e;
      logic o_d, o_b, o_c, o_x, o_r;
      o_d = k == 0 ? dout4 : dout1;
      o_b = k == 0 ? busy4 : busy1;
      o_c = k == 0 ? cd4 : cd1;
      o_x = k == 0 ? bad4 : bad1;
      o_r = k == 0 ? bus4.in_ready : bus1.in_ready;
      e = act[k] != 0 ? exp_at(cc[k], dcyc(k), tt[k]) : 2'b00;
      chk($sformatf("dout%0d", k), o_d, e[1]);
      chk($sformatf("char_done%0d", k), o_c, e[0]);
      chk($sformatf("busy%0d", k), o_b, act[k] != 0);
      chk($sformatf("in_ready%0d", k), o_r, act[k] == 0);
      chk($sformatf("bad_char%0d", k), o_x, xbad[k]);
      hi[k] += int'(o_d);
      bz[k] += int'(o_b);
      nd[k] += int'(o_c);
      nb[k] += int'(o_x);
      nr[k] += int'(!o_r);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v,
                       input logic [7:0] ch);
    if (k == 0) begin
      bus4.in_valid = v;
      bus4.in_char  = ch;
    end else begin
      bus1.in_valid = v;
      bus1.in_char  = ch;
    end
  endtask

  task automatic send(input int k, input logic [7:0] ch,
                      input bit hold);
    int n0, g;
    n0 = nx[k];
    g  = 0;
    drive(k, 1'b1, ch);
    while (nx[k] == n0 && g < 400) begin
      step();
      g++;
    end
    chk("xfer_timeout", nx[k] != n0, 1);
    if (!hold) drive(k, 1'b0, ch);
  endtask

  task automatic wait_idle(input int k);
    int g;
    g = 0;
    while (act[k] != 0 && g < 400) begin
      step();
      g++;
    end
    chk("idle_timeout", act[k] == 0, 1);
    step();
  endtask

  int h0, b0, d0, x0, r0;

  task automatic snap(input int k);
    h0 = hi[k]; b0 = bz[k]; d0 = nd[k];
    x0 = nb[k]; r0 = nr[k];
  endtask

  initial begin
    drive(0, 1'b0, 8'h0);
    drive(1, 1'b0, 8'h0);
    step();
    step();
    rst = 1'b0;
    step();

    chk("m_len_e", len_of("e", 4), 16);
    chk("m_len_A", len_of("A", 4), 32);
    chk("m_len_0", len_of("0", 4), 88);
    chk("m_len_sp", len_of(" ", 4), 16);
    chk("m_e_t3", exp_at("e", 4, 3), 2);
    chk("m_e_t4", exp_at("e", 4, 4), 0);
    chk("m_e_t15", exp_at("e", 4, 15), 1);
    chk("m_5_t8", exp_at("5", 4, 8), 2);

    snap(0);
    send(0, "e", 0);
    chk("e_c1_dout", dout4, 1);
    repeat (3) step();
    chk("e_c4_dout", dout4, 1);
    step();
    chk("e_c5_dout", dout4, 0);
    repeat (11) step();
    chk("e_c16_done", cd4, 1);
    step();
    chk("e_c17_ready", bus4.in_ready, 1);
    wait_idle(0);
    chk("e_high", hi[0] - h0, 4);

    snap(0);
    send(0, "A", 1);
    send(0, "a", 0);
    wait_idle(0);
    chk("Aa_high", hi[0] - h0, 32);
    chk("Aa_done", nd[0] - d0, 2);

    snap(0);
    send(0, "0", 0);
    wait_idle(0);
    chk("0_busy", bz[0] - b0, 88);
    chk("0_high", hi[0] - h0, 60);
    snap(0);
    send(0, "5", 0);
    wait_idle(0);
    chk("5_high", hi[0] - h0, 20);

    snap(0);
    send(0, " ", 0);
    wait_idle(0);
    chk("sp_busy", bz[0] - b0, 16);
    chk("sp_done", nd[0] - d0, 1);
    chk("sp_high", hi[0] - h0, 0);
    snap(0);
    send(0, "#", 0);
    repeat (4) step();
    chk("bad_pulse", nb[0] - x0, 1);
    chk("bad_rdy", nr[0] - r0, 0);
    chk("bad_high", hi[0] - h0, 0);

    send(0, "t", 0);
    repeat (5) step();
    chk("t_c6_dout", dout4, 1);
    rst = 1'b1;
    #1;
    chk("rst_dout", dout4, 0);
    chk("rst_busy", busy4, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", bus4.in_ready, 1);
    snap(0);
    send(0, "e", 0);
    wait_idle(0);
    chk("rst_e_high", hi[0] - h0, 4);
    chk("rst_e_done", nd[0] - d0, 1);

    snap(0);
    send(0, "q", 0);
    repeat (10) step();
    abort4 = 1'b1;
    step();
    abort4 = 1'b0;
    chk("ab_dout", dout4, 0);
    chk("ab_busy", busy4, 0);
    repeat (20) step();
    chk("ab_done", nd[0] - d0, 0);
    abort4 = 1'b1;
    step();
    abort4 = 1'b0;
    chk("ab_idle_rdy", bus4.in_ready, 1);

    snap(1);
    send(1, "e", 0);
    chk("d1_c1", dout1, 1);
    step();
    chk("d1_c2", dout1, 0);
    step();
    step();
    chk("d1_c4_done", cd1, 1);
    step();
    chk("d1_c5_rdy", bus1.in_ready, 1);
    wait_idle(1);
    chk("d1_high", hi[1] - h0, 1);
    snap(1);
    send(1, "q", 0);
    step();
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("d1_ab_dout", dout1, 0);
    repeat (10) step();
    chk("d1_ab_done", nd[1] - d0, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
